// File: rtl/simple_alu_arbiter.sv
// rtl/simple_alu_arbiter.sv - round-robin arbiter sharing one registered add/sub ALU
module simple_alu_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0]       req_op,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   alu_add0_sub1,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  input  logic [WIDTH-1:0]       alu_o,
  output logic                   busy,
  output logic [IDW-1:0]         grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic             pick_found;
  logic [IDW-1:0]   pick_idx;
  logic [IDW:0]     scan_sum;
  logic [IDW-1:0]   scan_idx;
  logic             pick_op;
  logic [WIDTH-1:0] pick_a;
  logic [WIDTH-1:0] pick_b;
  logic [IDW-1:0]   next_ptr;

  // First valid requester starting at rr_ptr and wrapping modulo N_REQ
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(N_REQ)) begin
        scan_sum = scan_sum - (IDW+1)'(N_REQ);
      end
      scan_idx = scan_sum[IDW-1:0];
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    pick_op = 1'b0;
    pick_a  = '0;
    pick_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDW'(i)) begin
        pick_op = req_op[i];
        pick_a  = req_a[i*WIDTH +: WIDTH];
        pick_b  = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign next_ptr = (grant_id_q == IDW'(N_REQ-1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    req_ready  = '0;
    rsp_valid  = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          // Gated by resetn so no accept is seen while reset is asserted
          req_ready[pick_idx] = resetn;
          grant_id_d          = pick_idx;
          op_d                = pick_op;
          a_d                 = pick_a;
          b_d                 = pick_b;
          state_d             = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        rsp_data_d = alu_o;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid[grant_id_q] = 1'b1;
        if (rsp_ready[grant_id_q]) begin
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      op_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign alu_add0_sub1 = op_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign rsp_data      = rsp_data_q;
  assign grant_id      = grant_id_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_simple_alu_arbiter.sv
// tb/tb_simple_alu_arbiter.sv - self-checking bench for simple_alu_arbiter
module tb_simple_alu_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           resetn;
  logic [N-1:0]   req_valid, req_ready, req_op, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   rsp_data, alu_a, alu_b, alu_o;
  logic           alu_add0_sub1, busy;
  logic [1:0]     grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level reference: age = cycles since acceptance (0 = free)
  int m_age = 0;
  int m_ptr = 0;
  int m_g   = 0;
  int m_win = 0;
  int m_res = 0;
  int acc_idx;

  typedef struct { int idx; int op; int a; int b; int exp; } vec_t;
  vec_t tbl[6];
  bit   pend[N];

  simple_alu_arbiter #(.N_REQ(N), .WIDTH(W), .IDW(2)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .alu_add0_sub1(alu_add0_sub1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_o(alu_o), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  initial alu_o = '0;
  always @(posedge clk) alu_o <= alu_add0_sub1 ? alu_a - alu_b : alu_a + alu_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int calc(int g);
    int a, b;
    a = int'(req_a[g*W +: W]);
    b = int'(req_b[g*W +: W]);
    return req_op[g] ? (a - b + 256) % 256 : (a + b) % 256;
  endfunction

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input int op, input int a, input int b);
    req_valid[i]     = 1'b1;
    req_op[i]        = op[0];
    req_a[i*W +: W]  = a[W-1:0];
    req_b[i*W +: W]  = b[W-1:0];
  endtask

  task automatic mid();
    logic [N-1:0] e_rr, e_rv;
    @(negedge clk);
    e_rr = '0;
    e_rv = '0;
    if (m_age == 0) begin
      m_win = pick();
      if (m_win >= 0) e_rr[m_win] = 1'b1;
    end else if (m_age >= 3) begin
      e_rv[m_g] = 1'b1;
    end
    chk("req_ready", req_ready, e_rr);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("busy", busy, m_age != 0);
    if (m_age != 0) chk("grant_id", grant_id, m_g);
    if (m_age >= 3) chk("rsp_data", rsp_data, m_res);
  endtask

  task automatic fin();
    acc_idx = -1;
    if (m_age == 0) begin
      if (m_win >= 0) begin
        m_g = m_win; m_res = calc(m_g); m_age = 1; acc_idx = m_g;
      end
    end else if (m_age >= 3) begin
      if (rsp_ready[m_g]) begin m_ptr = (m_g + 1) % N; m_age = 0; end
    end else begin
      m_age++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; req_valid = '0; rsp_ready = '1;
    m_age = 0; m_ptr = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    tbl[0] = '{0, 0, 100, 27, 127};
    tbl[1] = '{1, 1, 5, 10, 251};
    tbl[2] = '{1, 0, 200, 100, 44};
    tbl[3] = '{3, 1, 0, 1, 255};
    tbl[4] = '{2, 0, 255, 1, 0};
    tbl[5] = '{0, 1, 128, 128, 0};
    req_op = '0; req_a = '0; req_b = '0; req_valid = '0; rsp_ready = '1;
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_alu", {alu_add0_sub1, alu_a, alu_b}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    do_reset();

    // Single transactions with fixed latency and wrap cases
    for (int t = 0; t < 6; t++) begin
      set_req(tbl[t].idx, tbl[t].op, tbl[t].a, tbl[t].b);
      mid(); chk("tbl_ready", req_ready, 1 << tbl[t].idx); fin();
      req_valid = '0;
      mid(); chk("tbl_busy1", busy, 1); fin();
      mid(); chk("tbl_busy2", busy, 1); fin();
      mid();
      chk("tbl_rsp_valid", rsp_valid, 1 << tbl[t].idx);
      chk("tbl_rsp_data", rsp_data, tbl[t].exp);
      chk("tbl_busy3", busy, 1);
      fin();
      mid(); chk("tbl_idle", busy, 0); fin();
    end

    // Round-robin: all valid, grants 0,1,2,3,0 every 4 cycles
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, i % 2, 30 * i + 17, 3 * i + 200);
    for (int k = 0; k < 20; k++) begin
      mid();
      if (k % 4 == 0) chk("rr_grant", req_ready, 1 << ((k / 4) % N));
      if (k % 4 == 3) chk("rr_data", rsp_data, calc((k / 4) % N));
      fin();
    end
    req_valid = '0;
    repeat (4) begin mid(); fin(); end

    // Backpressure on requester 2, then pointer placement 3 before 0
    do_reset();
    set_req(2, 1, 9, 50);
    rsp_ready = 4'b1011;
    mid(); fin();
    req_valid = '0;
    set_req(0, 0, 1, 2);
    set_req(3, 0, 3, 4);
    mid(); fin(); mid(); fin();
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("bp_rsp_valid", rsp_valid, 4'b0100);
      chk("bp_rsp_data", rsp_data, 215);
      chk("bp_req_ready", req_ready, 0);
      fin();
    end
    rsp_ready = '1;
    mid(); fin();
    mid(); chk("ptr_grant3", req_ready, 4'b1000); fin();
    req_valid = '0;
    repeat (4) begin mid(); fin(); end

    // Asynchronous reset during CAPTURE drops the transaction
    do_reset();
    set_req(1, 0, 60, 70);
    mid(); fin();
    req_valid = '0;
    mid(); fin();
    mid();
    resetn = 1'b0;
    m_age = 0; m_ptr = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_alu", {alu_add0_sub1, alu_a, alu_b}, 0);
    chk("arst_grant_id", grant_id, 0);
    chk("arst_rsp_data", rsp_data, 0);
    @(posedge clk); #1;
    chk("arst_hold_rsp_valid", rsp_valid, 0);
    set_req(1, 0, 11, 22);
    set_req(0, 1, 33, 44);
    resetn = 1'b1;
    mid(); chk("arst_restart", req_ready, 4'b0001); fin();
    req_valid = '0;
    repeat (4) begin mid(); fin(); end

    // Randomized traffic against the reference model
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom % 3 == 0)) begin
          pend[i] = 1'b1;
          set_req(i, $urandom % 2, $urandom % 256, $urandom % 256);
        end else if (pend[i] && ($urandom % 25 == 0)) begin
          pend[i] = 1'b0;
        end
        req_valid[i] = pend[i];
        rsp_ready[i] = ($urandom % 4 != 0);
      end
      mid(); fin();
      if (acc_idx >= 0) pend[acc_idx] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/simple_alu_arbiter.md
Name: simple_alu_arbiter

Overview:
Shares one simple_alu instance (8-bit add/sub, one registered cycle of latency) between N_REQ requesters.
- Each requester presents an operation with a valid/ready handshake.
- The arbiter picks one request round-robin, drives the ALU, captures the registered result and returns it with a per-requester response handshake.
- Sits between the simple-ISA execute/issue logic and the shared ALU datapath.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, operand/result width; must match ALU width
IDW, $clog2(N_REQ), width of grant index

Ports:
clk  input  1  single clock, rising edge
resetn  input  1  asynchronous, active-low reset
req_valid  input  N_REQ  per-requester request valid
req_ready  output  N_REQ  per-requester accept, one-hot or zero
req_op  input  N_REQ  per-requester op, 0=add, 1=sub
req_a  input  N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
req_b  input  N_REQ*WIDTH  operand B, packed as req_a
rsp_valid  output  N_REQ  one-hot result valid to the granted requester
rsp_ready  input  N_REQ  per-requester result accept
rsp_data  output  WIDTH  result, shared bus, meaningful only with rsp_valid
alu_add0_sub1  output  1  to ALU op select
alu_a  output  WIDTH  to ALU operand A
alu_b  output  WIDTH  to ALU operand B
alu_o  input  WIDTH  from ALU registered result
busy  output  1  high in any state other than IDLE
grant_id  output  IDW  index of current/last granted requester

Behaviour:
- FSM states: IDLE, ISSUE, CAPTURE, RESP. Reset state is IDLE.
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, alu_add0_sub1=0, alu_a=0, alu_b=0, busy=0, grant_id=0, rr_ptr=0.
- IDLE, no req_valid set: remain in IDLE.
- IDLE, any req_valid set:
  - g = first index i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - req_ready[g]=1 combinationally in this cycle only; handshake completes this cycle.
  - Latch op/a/b of requester g into operand registers, latch g into grant_id, go to ISSUE.
- req_ready is 0 in every state except IDLE. Only one grant is in flight at a time.
- alu_add0_sub1/alu_a/alu_b are driven directly from the operand registers, so they are stable from ISSUE onwards until the next grant.
- ISSUE: the ALU samples the operands at the end of this cycle. Go to CAPTURE unconditionally.
- CAPTURE: alu_o holds the result. Register it into rsp_data and go to RESP.
- RESP:
  - rsp_valid[grant_id]=1, all other rsp_valid bits 0; rsp_data held stable.
  - Stay in RESP while rsp_ready[grant_id]=0. rsp_ready bits of other requesters are ignored.
  - On rsp_ready[grant_id]=1: set rr_ptr=(grant_id+1) mod N_REQ and go to IDLE. rsp_valid drops the following cycle.
- Latency: request accepted in cycle T; rsp_valid asserted in cycle T+3. With rsp_ready held high, minimum issue interval is 4 cycles.
- Arithmetic is modulo 2^WIDTH, with no carry or borrow flag; wrap comes from the ALU unchanged. The arbiter never modifies the data.
- Requester rules:
  - A requester holds req_op/req_a/req_b stable while req_valid is high and ready is low.
  - Dropping req_valid before ready is legal; that request is simply never granted.
- Simultaneous events:
  - Requests arriving during ISSUE/CAPTURE/RESP wait for IDLE.
  - A new request from the just-completed requester competes at lowest priority next round.
- rr_ptr advances only on response completion, never on grant alone.
- Asynchronous reset asserted mid-operation:
  - Immediately forces IDLE, clears rsp_valid/req_ready, clears operand registers.
  - The in-flight transaction is dropped with no response.
  - After release, arbitration restarts at rr_ptr=0.
- alu_o is ignored outside CAPTURE.

Test Plan:
- Single add: req 0 valid, op=0, A=100, B=27 -> req_ready[0] in cycle T, rsp_valid[0] at T+3, rsp_data=127, busy high T+1..T+3.
- Sub with borrow and add wrap: req 1 op=1, A=5, B=10 -> rsp_data=251 (0xFB); then req 1 op=0, A=200, B=100 -> rsp_data=44.
- Round-robin fairness: all 4 req_valid held high with distinct operands and rsp_ready high -> grants in order 0,1,2,3,0; each rsp_data matches its own operands; one grant every 4 cycles.
- Backpressure: rsp_ready[2] low for 5 cycles in RESP -> rsp_valid[2] and rsp_data held constant, req_ready stays 0 for the other pending requesters, grant proceeds only after rsp_ready[2]=1.
- Pointer placement: after completing requester 2, requesters 0 and 3 both valid -> requester 3 granted first.
- Reset mid-op: assert resetn=0 during CAPTURE -> all outputs return to reset values asynchronously, no rsp_valid pulse; after release, requesters 1 and 0 both valid -> requester 0 granted first.
